// File: rtl/envelope_pkg.sv
// Shared defaults, FSM state type and full-scale helper for the envelope generator.
package envelope_pkg;

  localparam int unsigned DEF_NUM_CH   = 4;
  localparam int unsigned DEF_VOL_W    = 4;
  localparam int unsigned DEF_PERIOD_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } env_state_e;

  // Full-scale volume for a given volume width.
  function automatic int unsigned vol_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/envelope_channel.sv
// One envelope channel: volume stepping every per_lat ticks until full scale or silence.
// Optional ENVELOPE_DAC_GATE_EN: a start=0/add=0 trigger leaves the channel silent and inactive.
module envelope_channel
  import envelope_pkg::*;
#(
  parameter int unsigned VOL_W    = DEF_VOL_W,
  parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_i,
  input  logic                trigger_i,
  input  logic                add_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [VOL_W-1:0]    start_i,
  output logic [VOL_W-1:0]    volume_o,
  output logic                active_o
);

  localparam logic [VOL_W-1:0] VMAX = VOL_W'(vol_max(VOL_W));

  env_state_e          state_q, state_d;
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W-1:0] per_lat_q, per_lat_d;
  logic                dir_q, dir_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vol_q     <= '0;
      timer_q   <= '0;
      per_lat_q <= '0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vol_q     <= vol_d;
      timer_q   <= timer_d;
      per_lat_q <= per_lat_d;
      dir_q     <= dir_d;
    end
  end

  // Trigger has priority over a coincident tick; a limit is detected on the step after it is reached.
  always_comb begin
    state_d   = state_q;
    vol_d     = vol_q;
    timer_d   = timer_q;
    per_lat_d = per_lat_q;
    dir_d     = dir_q;
    if (trigger_i) begin
      vol_d     = start_i;
      dir_d     = add_i;
      per_lat_d = period_i;
      timer_d   = period_i;
      state_d   = (period_i != '0) ? ST_RUN : ST_IDLE;
`ifdef ENVELOPE_DAC_GATE_EN
      // DAC-off: volume is already 0, so holding IDLE keeps both outputs gated until retrigger.
      if ((start_i == '0) && !add_i) begin
        state_d = ST_IDLE;
      end
`else
`endif
    end else if (tick_i && (state_q == ST_RUN)) begin
      if (timer_q > PERIOD_W'(1)) begin
        timer_d = timer_q - PERIOD_W'(1);
      end else begin
        timer_d = per_lat_q;
        if (dir_q) begin
          if (vol_q == VMAX) state_d = ST_IDLE;
          else               vol_d   = vol_q + VOL_W'(1);
        end else begin
          if (vol_q == '0)   state_d = ST_IDLE;
          else               vol_d   = vol_q - VOL_W'(1);
        end
      end
    end
  end

  assign volume_o = vol_q;
  assign active_o = (state_q == ST_RUN);

endmodule

// File: rtl/envelope_gen.sv
// Multi-channel volume envelope generator; slices packed register-file buses per channel.
// Optional ENVELOPE_DAC_GATE_EN enables DAC-off gating inside each channel.
module envelope_gen
  import envelope_pkg::*;
#(
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned VOL_W    = DEF_VOL_W,
  parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick_64,
  input  logic [NUM_CH-1:0]          trigger,
  input  logic [NUM_CH-1:0]          envelope_add,
  input  logic [NUM_CH*PERIOD_W-1:0] period,
  input  logic [NUM_CH*VOL_W-1:0]    starting_volume,
  output logic [NUM_CH*VOL_W-1:0]    volume,
  output logic [NUM_CH-1:0]          active
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    envelope_channel #(
      .VOL_W    (VOL_W),
      .PERIOD_W (PERIOD_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (tick_64),
      .trigger_i (trigger[i]),
      .add_i     (envelope_add[i]),
      .period_i  (period[i*PERIOD_W +: PERIOD_W]),
      .start_i   (starting_volume[i*VOL_W +: VOL_W]),
      .volume_o  (volume[i*VOL_W +: VOL_W]),
      .active_o  (active[i])
    );
  end

endmodule

// File: tb/tb_envelope_gen.sv
// Directed, table-driven bench for envelope_gen plus reset and DAC-gate sequences.
module tb_envelope_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_64 = 1'b0;
  logic [3:0]  trigger = '0;
  logic [3:0]  envelope_add = '0;
  logic [11:0] period = '0;
  logic [15:0] starting_volume = '0;
  logic [15:0] volume;
  logic [3:0]  active;

  int tests = 0;
  int fails = 0;

  envelope_gen #(.NUM_CH(4), .VOL_W(4), .PERIOD_W(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick_64         (tick_64),
    .trigger         (trigger),
    .envelope_add    (envelope_add),
    .period          (period),
    .starting_volume (starting_volume),
    .volume          (volume),
    .active          (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       ch;
    bit       trig;
    bit       tick;
    bit [3:0] start;
    bit       add;
    bit [2:0] per;
    bit [3:0] exp_vol;
    bit       exp_act;
    string    name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int ch, bit trig, bit tick, bit [3:0] start, bit add,
                              bit [2:0] per, bit [3:0] ev, bit ea, string name);
    vec_t v;
    v.ch = ch; v.trig = trig; v.tick = tick; v.start = start; v.add = add;
    v.per = per; v.exp_vol = ev; v.exp_act = ea; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input bit [3:0] start, input bit add, input bit [2:0] per);
    starting_volume[ch*4 +: 4] = start;
    envelope_add[ch]           = add;
    period[ch*3 +: 3]          = per;
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cycle(input logic [3:0] trg, input logic tk);
    trigger = trg;
    tick_64 = tk;
    @(posedge clk);
    #1;
    trigger = '0;
    tick_64 = 1'b0;
  endtask

  logic [3:0] gate_act;

  initial begin
    // ch0 down from 3, period 1
    vecs.push_back(mk(0, 1, 0, 3, 0, 1, 3, 1, "t1_trig"));
    vecs.push_back(mk(0, 0, 1, 3, 0, 1, 2, 1, "t1_tick1"));
    vecs.push_back(mk(0, 0, 1, 3, 0, 1, 1, 1, "t1_tick2"));
    vecs.push_back(mk(0, 0, 1, 3, 0, 1, 0, 1, "t1_tick3"));
    vecs.push_back(mk(0, 0, 1, 3, 0, 1, 0, 0, "t1_tick4"));
    vecs.push_back(mk(0, 0, 1, 3, 0, 1, 0, 0, "t1_tick5"));
    // ch1 up from 13, period 2
    vecs.push_back(mk(1, 1, 0, 13, 1, 2, 13, 1, "t2_trig"));
    vecs.push_back(mk(1, 0, 1, 13, 1, 2, 13, 1, "t2_tick1"));
    vecs.push_back(mk(1, 0, 1, 13, 1, 2, 14, 1, "t2_tick2"));
    vecs.push_back(mk(1, 0, 0, 13, 1, 2, 14, 1, "t2_idle"));
    vecs.push_back(mk(1, 0, 1, 13, 1, 2, 14, 1, "t2_tick3"));
    vecs.push_back(mk(1, 0, 1, 13, 1, 2, 15, 1, "t2_tick4"));
    vecs.push_back(mk(1, 0, 1, 13, 1, 2, 15, 1, "t2_tick5"));
    vecs.push_back(mk(1, 0, 1, 13, 1, 2, 15, 0, "t2_tick6"));
    vecs.push_back(mk(1, 0, 1, 13, 1, 2, 15, 0, "t2_tick7"));
    vecs.push_back(mk(1, 0, 1, 13, 1, 2, 15, 0, "t2_tick8"));
    // ch0 trigger coincident with tick
    vecs.push_back(mk(0, 1, 1, 9, 0, 1, 9, 1, "t4_trig_tick"));
    vecs.push_back(mk(0, 0, 0, 9, 0, 1, 9, 1, "t4_idle"));
    vecs.push_back(mk(0, 0, 1, 9, 0, 1, 8, 1, "t4_tick1"));
    vecs.push_back(mk(0, 0, 1, 9, 0, 1, 7, 1, "t4_tick2"));
    // ch3 period latched only on trigger
    vecs.push_back(mk(3, 1, 0, 10, 0, 3, 10, 1, "t5_trig"));
    vecs.push_back(mk(3, 0, 1, 10, 0, 3, 10, 1, "t5_tick1"));
    vecs.push_back(mk(3, 0, 1, 10, 0, 3, 10, 1, "t5_tick2"));
    vecs.push_back(mk(3, 0, 1, 10, 0, 3, 9, 1, "t5_tick3"));
    vecs.push_back(mk(3, 0, 1, 10, 0, 1, 9, 1, "t5_chg_tick4"));
    vecs.push_back(mk(3, 0, 1, 10, 0, 1, 9, 1, "t5_chg_tick5"));
    vecs.push_back(mk(3, 0, 1, 10, 0, 1, 8, 1, "t5_chg_tick6"));
    vecs.push_back(mk(3, 1, 0, 10, 0, 1, 10, 1, "t5_retrig"));
    vecs.push_back(mk(3, 0, 1, 10, 0, 1, 9, 1, "t5_rt_tick1"));
    vecs.push_back(mk(3, 0, 1, 10, 0, 1, 8, 1, "t5_rt_tick2"));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_volume", int'(volume), 0);
    check("reset_active", int'(active), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      set_ch(vecs[k].ch, vecs[k].start, vecs[k].add, vecs[k].per);
      cycle(vecs[k].trig ? (4'b0001 << vecs[k].ch) : 4'b0000, vecs[k].tick);
      check({vecs[k].name, "_vol"}, int'(volume[vecs[k].ch*4 +: 4]), int'(vecs[k].exp_vol));
      check({vecs[k].name, "_act"}, int'(active[vecs[k].ch]), int'(vecs[k].exp_act));
    end

    // Period 0 freezes the starting volume
    set_ch(2, 7, 0, 0);
    cycle(4'b0100, 1'b0);
    check("t3_trig_vol", int'(volume[8 +: 4]), 7);
    check("t3_trig_act", int'(active[2]), 0);
    for (int i = 0; i < 20; i++) cycle(4'b0000, 1'b1);
    check("t3_frozen_vol", int'(volume[8 +: 4]), 7);
    check("t3_frozen_act", int'(active[2]), 0);

    // Simultaneous triggers, then asynchronous reset mid-envelope
    for (int c = 0; c < 4; c++) set_ch(c, 8, 1, 1);
    cycle(4'b1111, 1'b0);
    check("t6_all_vol", int'(volume), 16'h8888);
    check("t6_all_act", int'(active), 4'hF);
    cycle(4'b0000, 1'b1);
    check("t6_step_vol", int'(volume), 16'h9999);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_vol", int'(volume), 0);
    check("t6_async_act", int'(active), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    check("t6_post_rst_vol", int'(volume), 0);
    check("t6_post_rst_act", int'(active), 0);

    // Start 0 / down trigger: DAC-off when gated, else frozen 0 until first step
`ifdef ENVELOPE_DAC_GATE_EN
    gate_act = 4'b0000;
`else
    gate_act = 4'b0001;
`endif
    set_ch(0, 0, 0, 2);
    cycle(4'b0001, 1'b0);
    check("t6_dac_trig_vol", int'(volume[3:0]), 0);
    check("t6_dac_trig_act", int'(active[0]), int'(gate_act[0]));
    cycle(4'b0000, 1'b1);
    check("t6_dac_tick1_act", int'(active[0]), int'(gate_act[0]));
    cycle(4'b0000, 1'b1);
    check("t6_dac_tick2_vol", int'(volume[3:0]), 0);
    check("t6_dac_tick2_act", int'(active[0]), 0);
    set_ch(0, 5, 0, 2);
    cycle(4'b0001, 1'b0);
    check("t6_dac_clear_vol", int'(volume[3:0]), 5);
    check("t6_dac_clear_act", int'(active[0]), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
